// File: rtl/smvm_row_accumulator.sv
// Sparse matrix-vector row accumulator: multiplies decoded lane triples by x[col_id] and folds per-lane row sums into y.
// Build option: define SMVM_ACC_SATURATE_EN to make every accumulate into acc and y saturate instead of wrap.
`timescale 1ns/1ps
module smvm_row_accumulator #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_W       = 32,
    parameter int MAX_DIM      = 64,
    localparam int IDX_W       = $clog2(MAX_DIM)
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       start,
    input  logic                       x_wr_en,
    input  logic [IDX_W-1:0]           x_wr_addr,
    input  logic [DATA_W-1:0]          x_wr_data,
    input  logic                       in_vld,
    input  logic [NUM_CHANNELS*32-1:0] values,
    input  logic [NUM_CHANNELS*32-1:0] col_id,
    input  logic [NUM_CHANNELS*32-1:0] row_id,
    input  logic                       matrix_done,
    input  logic [IDX_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       idx_err
);

    localparam int LANE_W = 32;
    localparam int CNT_W  = $clog2(NUM_CHANNELS + 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(NUM_CHANNELS + 1);
    localparam logic [IDX_W:0]   DIM_LIM    = (IDX_W + 1)'(MAX_DIM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] sum;
        sum = a + b;
`ifdef SMVM_ACC_SATURATE_EN
        return ((a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1])) ?
               {a[DATA_W-1], {(DATA_W-1){~a[DATA_W-1]}}} : sum;
`else
        return sum;
`endif
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic               start_clr_s;
    logic               capture_s;

    logic [DATA_W-1:0]  x_r [MAX_DIM];
    logic [DATA_W-1:0]  y_r [MAX_DIM];
    logic [DATA_W-1:0]  y_s [MAX_DIM];

    logic [DATA_W-1:0]  ln_val_s [NUM_CHANNELS];
    logic [DATA_W-1:0]  ln_x_s   [NUM_CHANNELS];
    logic [IDX_W-1:0]   ln_row_s [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ln_col_ok_s;
    logic [NUM_CHANNELS-1:0] ln_row_ok_s;
    logic [NUM_CHANNELS-1:0] ln_nz_s;
    logic [NUM_CHANNELS-1:0] ln_vld_s;
    logic [NUM_CHANNELS-1:0] ln_err_s;

    logic [NUM_CHANNELS-1:0] s1_vld_r;
    logic [DATA_W-1:0]  s1_val_r [NUM_CHANNELS];
    logic [DATA_W-1:0]  s1_x_r   [NUM_CHANNELS];
    logic [IDX_W-1:0]   s1_row_r [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] s2_vld_r;
    logic [DATA_W-1:0]  s2_prod_r [NUM_CHANNELS];
    logic [IDX_W-1:0]   s2_row_r  [NUM_CHANNELS];

    logic [DATA_W-1:0]  acc_r [NUM_CHANNELS];
    logic [DATA_W-1:0]  acc_s [NUM_CHANNELS];
    logic [IDX_W-1:0]   tag_r [NUM_CHANNELS];
    logic [IDX_W-1:0]   tag_s [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] tag_vld_r;
    logic [NUM_CHANNELS-1:0] tag_vld_s;
    logic [NUM_CHANNELS-1:0] fl_en_s;
    logic [NUM_CHANNELS-1:0] drain_s;

    assign start_clr_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign capture_s   = in_vld && (state_r == ST_RUN);
    assign ln_vld_s    = ln_nz_s & ln_row_ok_s;
    assign ln_err_s    = ln_nz_s & ~(ln_col_ok_s & ln_row_ok_s);

    // State register and FLUSH phase counter
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            flush_cnt_r <= (state_r == ST_FLUSH) ? (flush_cnt_r + CNT_W'(1)) : {CNT_W{1'b0}};
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = start ? ST_RUN : ST_IDLE;
            ST_RUN:   state_s = matrix_done ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_s = (flush_cnt_r == DRAIN_LAST) ? ST_DONE : ST_FLUSH;
            ST_DONE:  state_s = start ? ST_RUN : ST_DONE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Registered status outputs and y read port
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_data <= {DATA_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            idx_err <= 1'b0;
        end else begin
            rd_data <= ({1'b0, rd_addr} < DIM_LIM) ? y_r[rd_addr] : {DATA_W{1'b0}};
            busy    <= (state_s == ST_RUN) || (state_s == ST_FLUSH);
            done    <= (state_r == ST_FLUSH) && (state_s == ST_DONE);
            idx_err <= idx_err | (capture_s & (|ln_err_s));
        end
    end

    // x is frozen while a matrix is in flight
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int k = 0; k < MAX_DIM; k++) begin
                x_r[k] <= {DATA_W{1'b0}};
            end
        end else if (x_wr_en && (state_r != ST_RUN) && (state_r != ST_FLUSH) &&
                     ({1'b0, x_wr_addr} < DIM_LIM)) begin
            x_r[x_wr_addr] <= x_wr_data;
        end
    end

    // Lane decode: range checks, bubble detection and x lookup
    always_comb begin
        for (int l = 0; l < NUM_CHANNELS; l++) begin
            ln_val_s[l]    = DATA_W'(values[l*LANE_W +: LANE_W]);
            ln_nz_s[l]     = |values[l*LANE_W +: LANE_W];
            ln_col_ok_s[l] = col_id[l*LANE_W +: LANE_W] < LANE_W'(MAX_DIM);
            ln_row_ok_s[l] = row_id[l*LANE_W +: LANE_W] < LANE_W'(MAX_DIM);
            ln_row_s[l]    = row_id[l*LANE_W +: IDX_W];
            ln_x_s[l]      = ln_col_ok_s[l] ? x_r[col_id[l*LANE_W +: IDX_W]] : {DATA_W{1'b0}};
        end
    end

    // S1 capture and S2 multiply; valids only enter in RUN so FLUSH drains naturally
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_vld_r <= {NUM_CHANNELS{1'b0}};
            s2_vld_r <= {NUM_CHANNELS{1'b0}};
            for (int l = 0; l < NUM_CHANNELS; l++) begin
                s1_val_r[l]  <= {DATA_W{1'b0}};
                s1_x_r[l]    <= {DATA_W{1'b0}};
                s1_row_r[l]  <= {IDX_W{1'b0}};
                s2_prod_r[l] <= {DATA_W{1'b0}};
                s2_row_r[l]  <= {IDX_W{1'b0}};
            end
        end else if (start_clr_s) begin
            s1_vld_r <= {NUM_CHANNELS{1'b0}};
            s2_vld_r <= {NUM_CHANNELS{1'b0}};
        end else begin
            s1_vld_r <= ln_vld_s & {NUM_CHANNELS{capture_s}};
            s2_vld_r <= s1_vld_r;
            for (int l = 0; l < NUM_CHANNELS; l++) begin
                s1_val_r[l]  <= ln_val_s[l];
                s1_x_r[l]    <= ln_x_s[l];
                s1_row_r[l]  <= ln_row_s[l];
                s2_prod_r[l] <= s1_val_r[l] * s1_x_r[l];
                s2_row_r[l]  <= s1_row_r[l];
            end
        end
    end

    // S3 per-lane accumulate, row-change flush, and end-of-matrix drain
    always_comb begin
        for (int l = 0; l < NUM_CHANNELS; l++) begin
            drain_s[l]   = (state_r == ST_FLUSH) && (flush_cnt_r == CNT_W'(l + 2));
            acc_s[l]     = acc_r[l];
            tag_s[l]     = tag_r[l];
            tag_vld_s[l] = tag_vld_r[l];
            fl_en_s[l]   = 1'b0;
            if (drain_s[l]) begin
                fl_en_s[l]   = tag_vld_r[l];
                acc_s[l]     = {DATA_W{1'b0}};
                tag_vld_s[l] = 1'b0;
            end else if (s2_vld_r[l] && tag_vld_r[l] && (s2_row_r[l] == tag_r[l])) begin
                acc_s[l] = acc_add(acc_r[l], s2_prod_r[l]);
            end else if (s2_vld_r[l]) begin
                fl_en_s[l]   = tag_vld_r[l];
                acc_s[l]     = s2_prod_r[l];
                tag_s[l]     = s2_row_r[l];
                tag_vld_s[l] = 1'b1;
            end else begin
                fl_en_s[l] = 1'b0;
            end
        end
    end

    // Merge all lane flushes per row so simultaneous flushes to one row all land
    always_comb begin : y_merge
        logic [DATA_W-1:0] sum_v;
        sum_v = {DATA_W{1'b0}};
        for (int k = 0; k < MAX_DIM; k++) begin
            sum_v = y_r[k];
            for (int l = 0; l < NUM_CHANNELS; l++) begin
                sum_v = (fl_en_s[l] && (tag_r[l] == IDX_W'(k))) ? acc_add(sum_v, acc_r[l]) : sum_v;
            end
            y_s[k] = sum_v;
        end
    end

    // Lane accumulators, row tags and result vector
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tag_vld_r <= {NUM_CHANNELS{1'b0}};
            for (int l = 0; l < NUM_CHANNELS; l++) begin
                acc_r[l] <= {DATA_W{1'b0}};
                tag_r[l] <= {IDX_W{1'b0}};
            end
            for (int k = 0; k < MAX_DIM; k++) begin
                y_r[k] <= {DATA_W{1'b0}};
            end
        end else if (start_clr_s) begin
            tag_vld_r <= {NUM_CHANNELS{1'b0}};
            for (int l = 0; l < NUM_CHANNELS; l++) begin
                acc_r[l] <= {DATA_W{1'b0}};
                tag_r[l] <= {IDX_W{1'b0}};
            end
            for (int k = 0; k < MAX_DIM; k++) begin
                y_r[k] <= {DATA_W{1'b0}};
            end
        end else begin
            tag_vld_r <= tag_vld_s;
            for (int l = 0; l < NUM_CHANNELS; l++) begin
                acc_r[l] <= acc_s[l];
                tag_r[l] <= tag_s[l];
            end
            for (int k = 0; k < MAX_DIM; k++) begin
                y_r[k] <= y_s[k];
            end
        end
    end

endmodule
